lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Memory-access stage directly upstream of the write-back stage.
- Accepts one load/store per request from execute and drives a multi-cycle data-memory bus with a req/ack handshake.
- Performs byte-lane steering, byte-enable generation and alignment checking.
- Presents the load result right-justified and zero-extended on dmem_out, together with the registered mem_ld_signed and mem_access_size that write-back uses for sign extension.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles waiting for mem_ack before abort. Used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request valid from execute; sampled only in IDLE
- is_store  in  1  1=store, 0=load
- addr  in  32  byte address (alu result)
- wdata  in  32  store data, right-justified
- access_size  in  2  00=byte, 01=half, 10=word, 11=reserved
- ld_signed  in  1  load sign-extend request, passed through to write-back
- mem_req  out  1  bus request
- mem_we  out  1  bus write enable
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- mem_wdata  out  32  lane-steered store data
- mem_be  out  4  byte enables
- mem_ack  in  1  bus acknowledge; rdata valid in same cycle for loads
- mem_rdata  in  32  bus read data
- busy  out  1  pipeline stall; high in every state except IDLE
- done  out  1  one-cycle completion pulse
- fault  out  1  valid with done; misaligned/reserved size (or timeout)
- dmem_out  out  32  load result, lane-shifted and zero-extended
- mem_ld_signed  out  1  registered ld_signed of the last accepted request
- mem_access_size  out  2  registered access_size of the last accepted request

Behaviour:
- Reset values: all outputs 0; state IDLE. Reset asserted mid-access drops mem_req immediately (asynchronous) with no completion pulse.
- States: IDLE, ACCESS, DONE, FAULT.
- IDLE:
  - With start=1, latch addr, is_store, wdata, access_size and ld_signed.
  - Go to FAULT if misaligned; otherwise go to ACCESS.
  - Misaligned means half with addr[0]=1, word with addr[1:0]!=0, or size 11.
- ACCESS:
  - mem_req=1 and mem_we=is_store. mem_addr, mem_be and mem_wdata are held constant until ack.
  - On mem_ack=1: capture the load result and go to DONE. mem_req falls in the next cycle.
- DONE: done=1, fault=0 for one cycle, then IDLE.
- FAULT: done=1, fault=1 for one cycle, no bus request, dmem_out unchanged, then IDLE.
- Minimum latency: start to done is 3 cycles with ack in the first ACCESS cycle. A fault takes 2 cycles.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
- Store steering: mem_wdata = wdata<<(8*addr[1:0]) for byte and half; unchanged for word.
- Load result: dmem_out = (mem_rdata>>(8*addr[1:0])), masked to 8/16/32 bits.
  - Upper bits are always zero; write-back applies sign extension from mem_ld_signed.
- dmem_out is updated only on a completed load and holds otherwise. Stores and faults leave it unchanged.
- mem_ld_signed and mem_access_size update when a request is accepted and hold until the next accept.
- start while busy=1 is ignored. The requester holds start until busy is seen. A start in the DONE/FAULT cycle is not accepted; it is taken in the following IDLE cycle.
- mem_ack outside ACCESS is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An ACCESS cycle counter resets on entry to ACCESS.
  - If TIMEOUT_CYCLES cycles pass with no mem_ack, deassert mem_req and go to FAULT (done=1, fault=1, dmem_out unchanged).
  - An ack arriving in the same cycle as timeout wins and completes normally.
- Not defined: no counter; ACCESS waits indefinitely for mem_ack.

Test Plan:
- Word load: addr=0x100, size=10, rdata=0xDEADBEEF, ack in first ACCESS cycle -> mem_be=1111, mem_addr=0x100, dmem_out=0xDEADBEEF, done on cycle 3.
- Signed byte load: addr=0x103, size=00, ld_signed=1, rdata=0x80FF1234 -> mem_be=1000, dmem_out=0x00000080, mem_ld_signed=1.
- Half store: addr=0x202, size=01, wdata=0x0000ABCD, ack after 4 wait cycles -> mem_we=1, mem_be=1100, mem_wdata=0xABCD0000 held stable, dmem_out unchanged.
- Misaligned word: addr=0x101, size=10 -> no mem_req, done=1 and fault=1 two cycles after start. Same for size=11.
- Back-to-back: start held high across two loads -> second accepted only after DONE returns to IDLE; reset asserted during ACCESS -> mem_req=0 immediately, no done.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=16: never ack -> mem_req drops and done=1, fault=1 after exactly 16 ACCESS cycles.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: one load/store per request over a req/ack data bus,
// with byte-lane steering, byte-enable generation and alignment checking.
// Optional ACCESS timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_store,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [1:0]  access_size,
   input  logic        ld_signed,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic [31:0] dmem_out,
   output logic        mem_ld_signed,
   output logic [1:0]  mem_access_size
);

   typedef enum logic [1:0] {StIdle, StAccess, StDone, StFault} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] dmem_q, dmem_d;
   logic        is_store_q, is_store_d;
   logic        ld_signed_q, ld_signed_d;
   logic [1:0]  size_q, size_d;

   logic        misaligned;
   logic        timeout;
   logic [4:0]  shamt;
   logic [3:0]  be_raw;
   logic [31:0] wdata_steer;
   logic [31:0] rdata_shift;
   logic [31:0] load_res;

   // Alignment check on the incoming request (size 11 is reserved).
   always_comb begin
      misaligned = 1'b0;
      case (access_size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = addr[0];
         2'b10:   misaligned = |addr[1:0];
         default: misaligned = 1'b1;
      endcase
   end

   // Lane steering for the latched request: byte enables, store data, load result.
   always_comb begin
      shamt       = {addr_q[1:0], 3'b000};
      be_raw      = 4'b1111;
      wdata_steer = wdata_q;
      rdata_shift = mem_rdata >> shamt;
      load_res    = rdata_shift;
      case (size_q)
         2'b00: begin
            be_raw      = 4'b0001 << addr_q[1:0];
            wdata_steer = wdata_q << shamt;
            load_res    = {24'h000000, rdata_shift[7:0]};
         end
         2'b01: begin
            be_raw      = 4'b0011 << addr_q[1:0];
            wdata_steer = wdata_q << shamt;
            load_res    = {16'h0000, rdata_shift[15:0]};
         end
         default: begin
            be_raw      = 4'b1111;
            wdata_steer = wdata_q;
            load_res    = rdata_shift;
         end
      endcase
   end

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;

   // Counts ACCESS cycles; held at zero elsewhere so it restarts on every entry.
   always_comb begin
      cnt_d = '0;
      if (state_q == StAccess) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Timeout counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Fires in the last allowed ACCESS cycle; an ack in that cycle still wins.
   assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
   // Parameter only matters when the timeout is built in.
   logic unused_timeout_cycles;
   assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif

   // Next-state and request-latch logic.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      is_store_d  = is_store_q;
      ld_signed_d = ld_signed_q;
      size_d      = size_q;
      dmem_d      = dmem_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               addr_d      = addr;
               wdata_d     = wdata;
               is_store_d  = is_store;
               ld_signed_d = ld_signed;
               size_d      = access_size;
               state_d     = misaligned ? StFault : StAccess;
            end
         end
         StAccess: begin
            if (mem_ack) begin
               if (!is_store_q) begin
                  dmem_d = load_res;
               end
               state_d = StDone;
            end else if (timeout) begin
               state_d = StFault;
            end
         end
         StDone:  state_d = StIdle;
         StFault: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State and request registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         wdata_q     <= '0;
         is_store_q  <= 1'b0;
         ld_signed_q <= 1'b0;
         size_q      <= 2'b00;
         dmem_q      <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         is_store_q  <= is_store_d;
         ld_signed_q <= ld_signed_d;
         size_q      <= size_d;
         dmem_q      <= dmem_d;
      end
   end

   // Bus outputs are driven only in ACCESS so they read zero in every other state.
   always_comb begin
      mem_req         = (state_q == StAccess);
      mem_we          = mem_req & is_store_q;
      mem_addr        = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
      mem_wdata       = mem_req ? wdata_steer : 32'h0;
      mem_be          = mem_req ? be_raw : 4'b0000;
      busy            = (state_q != StIdle);
      done            = (state_q == StDone) || (state_q == StFault);
      fault           = (state_q == StFault);
      dmem_out        = dmem_q;
      mem_ld_signed   = ld_signed_q;
      mem_access_size = size_q;
   end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: a driver issues directed requests and
// pushes expected bus/result entries; a bus responder and a completion monitor
// pop and compare independently.
module tb_lsu_mem_stage;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        is_store;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [1:0]  access_size;
   logic        ld_signed;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        done;
   logic        fault;
   logic [31:0] dmem_out;
   logic        mem_ld_signed;
   logic [1:0]  mem_access_size;

   lsu_mem_stage #(
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .is_store       (is_store),
      .addr           (addr),
      .wdata          (wdata),
      .access_size    (access_size),
      .ld_signed      (ld_signed),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_be         (mem_be),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata),
      .busy           (busy),
      .done           (done),
      .fault          (fault),
      .dmem_out       (dmem_out),
      .mem_ld_signed  (mem_ld_signed),
      .mem_access_size(mem_access_size)
   );

   typedef struct {
      logic        flt;
      logic [31:0] dmem;
      logic        sgn;
      logic [1:0]  size;
      int          start_cyc;
      int          lat;
   } res_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] rdata;
      int          waits;
   } bus_t;

   res_t res_q[$];
   bus_t bus_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic bound_fail(input string nm);
      n_cmp++;
      n_err++;
      $display("FAIL %s: wait expired (t=%0t)", nm, $time);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) bound_fail("wait_idle");
   endtask

   task automatic wait_busy();
      bit ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (busy) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) bound_fail("wait_busy");
   endtask

   // waits < 0 marks a request that must never reach the bus.
   task automatic do_req(input logic st, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic sg, input logic [31:0] rd,
                         input int waits, input logic flt, input logic [3:0] be,
                         input logic [31:0] mwd, input logic [31:0] dm, input int lat);
      wait_idle();
      is_store    = st;
      addr        = a;
      wdata       = wd;
      access_size = sz;
      ld_signed   = sg;
      start       = 1'b1;
      res_q.push_back('{flt: flt, dmem: dm, sgn: sg, size: sz, start_cyc: cyc, lat: lat});
      if (waits >= 0) begin
         bus_q.push_back('{we: st, addr: {a[31:2], 2'b00}, wdata: mwd, be: be, rdata: rd,
                           waits: waits});
      end
      @(negedge clk);
      wait_busy();
      start = 1'b0;
   endtask

   // Bus responder: checks request fields every cycle of ACCESS, then acks.
   initial begin
      bus_t b;
      bit   aborted;
      mem_ack   = 1'b0;
      mem_rdata = 32'hBAD0BAD0;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            if (bus_q.size() == 0) begin
               chk("unexpected mem_req", 32'(mem_req), 32'd0);
               for (int i = 0; i < 50 && mem_req; i++) @(negedge clk);
            end else begin
               b = bus_q.pop_front();
               aborted = 1'b0;
               for (int w = 0; w <= b.waits; w++) begin
                  if (w > 0) @(negedge clk);
                  if (!mem_req) begin
                     aborted = 1'b1;
                     break;
                  end
                  chk("mem_we", 32'(mem_we), 32'(b.we));
                  chk("mem_addr", mem_addr, b.addr);
                  chk("mem_be", 32'(mem_be), 32'(b.be));
                  chk("mem_wdata", mem_wdata, b.wdata);
               end
               if (!aborted) begin
                  mem_ack   = 1'b1;
                  mem_rdata = b.we ? 32'hFFFFFFFF : b.rdata;
                  @(negedge clk);
                  mem_ack   = 1'b0;
                  mem_rdata = 32'hBAD0BAD0;
               end
            end
         end
      end
   end

   // Completion monitor: every done pulse must match the oldest expected result.
   initial begin
      res_t r;
      forever begin
         @(negedge clk);
         if (done) begin
            if (res_q.size() == 0) begin
               chk("unexpected done", 32'(done), 32'd0);
            end else begin
               r = res_q.pop_front();
               chk("fault", 32'(fault), 32'(r.flt));
               chk("dmem_out", dmem_out, r.dmem);
               chk("mem_ld_signed", 32'(mem_ld_signed), 32'(r.sgn));
               chk("mem_access_size", 32'(mem_access_size), 32'(r.size));
               chk("latency", 32'(cyc - r.start_cyc), 32'(r.lat));
               chk("mem_req at done", 32'(mem_req), 32'd0);
            end
         end
      end
   end

   // Backstop against a hung run.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, " mem_req"}, 32'(mem_req), 32'd0);
      chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
      chk({tag, " mem_addr"}, mem_addr, 32'd0);
      chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
      chk({tag, " mem_be"}, 32'(mem_be), 32'd0);
      chk({tag, " busy"}, 32'(busy), 32'd0);
      chk({tag, " done"}, 32'(done), 32'd0);
      chk({tag, " fault"}, 32'(fault), 32'd0);
      chk({tag, " dmem_out"}, dmem_out, 32'd0);
      chk({tag, " mem_ld_signed"}, 32'(mem_ld_signed), 32'd0);
      chk({tag, " mem_access_size"}, 32'(mem_access_size), 32'd0);
   endtask

   // Driver.
   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      is_store    = 1'b0;
      addr        = 32'h0;
      wdata       = 32'h0;
      access_size = 2'b00;
      ld_signed   = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;

      // Word load, ack in the first ACCESS cycle.
      do_req(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 0, 1'b0, 4'b1111, 32'h0,
             32'hDEADBEEF, 2);
      // Signed byte load from the top lane.
      do_req(1'b0, 32'h103, 32'h0, 2'b00, 1'b1, 32'h80FF1234, 0, 1'b0, 4'b1000, 32'h0,
             32'h00000080, 2);
      // Half store with four wait cycles; dmem_out holds.
      do_req(1'b1, 32'h202, 32'h0000ABCD, 2'b01, 1'b0, 32'h0, 4, 1'b0, 4'b1100, 32'hABCD0000,
             32'h00000080, 6);
      // Misaligned word and reserved size fault without a bus request.
      do_req(1'b0, 32'h101, 32'h0, 2'b10, 1'b0, 32'h0, -1, 1'b1, 4'b0000, 32'h0,
             32'h00000080, 1);
      do_req(1'b0, 32'h104, 32'h0, 2'b11, 1'b0, 32'h0, -1, 1'b1, 4'b0000, 32'h0,
             32'h00000080, 1);
      // Upper half load with one wait cycle.
      do_req(1'b0, 32'h302, 32'h0, 2'b01, 1'b0, 32'h12345678, 1, 1'b0, 4'b1100, 32'h0,
             32'h00001234, 3);
      // Byte store into lane 1.
      do_req(1'b1, 32'h401, 32'h000000A5, 2'b00, 1'b0, 32'h0, 0, 1'b0, 4'b0010, 32'h0000A500,
             32'h00001234, 2);
      // Misaligned half.
      do_req(1'b0, 32'h403, 32'h0, 2'b01, 1'b1, 32'h0, -1, 1'b1, 4'b0000, 32'h0,
             32'h00001234, 1);
      // Byte load from lane 2, two wait cycles.
      do_req(1'b0, 32'h502, 32'h0, 2'b00, 1'b0, 32'h11223344, 2, 1'b0, 4'b0100, 32'h0,
             32'h00000022, 4);

      // Back-to-back with start held: the second request waits for IDLE after DONE.
      wait_idle();
      is_store    = 1'b0;
      addr        = 32'h600;
      wdata       = 32'h0;
      access_size = 2'b10;
      ld_signed   = 1'b0;
      start       = 1'b1;
      res_q.push_back('{flt: 1'b0, dmem: 32'hCAFEF00D, sgn: 1'b0, size: 2'b10, start_cyc: cyc,
                        lat: 2});
      bus_q.push_back('{we: 1'b0, addr: 32'h600, wdata: 32'h0, be: 4'b1111, rdata: 32'hCAFEF00D,
                        waits: 0});
      @(negedge clk);
      wait_busy();
      addr        = 32'h601;
      access_size = 2'b00;
      res_q.push_back('{flt: 1'b0, dmem: 32'h000000AB, sgn: 1'b0, size: 2'b00, start_cyc: cyc,
                        lat: 4});
      bus_q.push_back('{we: 1'b0, addr: 32'h600, wdata: 32'h0, be: 4'b0010, rdata: 32'h0000AB00,
                        waits: 0});
      wait_idle();
      @(negedge clk);
      wait_busy();
      start = 1'b0;

      // Reset in the middle of ACCESS: mem_req drops at once, no done pulse.
      wait_idle();
      is_store    = 1'b0;
      addr        = 32'h800;
      access_size = 2'b10;
      ld_signed   = 1'b1;
      start       = 1'b1;
      bus_q.push_back('{we: 1'b0, addr: 32'h800, wdata: 32'h0, be: 4'b1111, rdata: 32'h0,
                        waits: 1000});
      @(negedge clk);
      wait_busy();
      start = 1'b0;
      @(negedge clk);
      chk("mem_req before reset", 32'(mem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("mem_req at reset", 32'(mem_req), 32'd0);
      chk("busy at reset", 32'(busy), 32'd0);
      @(negedge clk);
      chk_reset_vals("mid-reset");
      #1 rst_n = 1'b1;

      // Normal operation after the aborted access.
      do_req(1'b0, 32'h700, 32'h0, 2'b10, 1'b0, 32'h01020304, 0, 1'b0, 4'b1111, 32'h0,
             32'h01020304, 2);

`ifdef LSU_TIMEOUT_EN
      // Never acked: 16 ACCESS cycles, then FAULT.
      do_req(1'b0, 32'h900, 32'h0, 2'b10, 1'b0, 32'h0, 1000, 1'b1, 4'b1111, 32'h0,
             32'h01020304, 17);
`endif

      for (int i = 0; i < 300 && res_q.size() != 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("results drained", 32'(res_q.size()), 32'd0);
      chk("bus entries drained", 32'(bus_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
